// File: rtl/sys_array_sequencer.sv
// Wave sequencer for an N x N systolic MAC array: snapshots A/B, feeds skewed
// diagonal operand waves into the array edges and handshakes start/done per wave.
`timescale 1ns/1ps

module sys_array_sequencer #(
  parameter int N        = 3,
  parameter int W        = 8,
  parameter int TICK_DIV = 11,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N*N*W-1:0]            a_flat,
  input  logic [N*N*W-1:0]            b_flat,
  input  logic [N*N-1:0]              mac_done,
  output logic [N*N-1:0]              mac_start,
  output logic [N*W-1:0]              a_row_in,
  output logic [N*W-1:0]              b_col_in,
  output logic [$clog2(3*N-2)-1:0]    wave,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int WAVE_W    = $clog2(3*N-2);
  localparam int LAST_WAVE = 3*N-3;
  localparam int TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WDW       = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [TCW-1:0]       tick_cnt_reg, tick_cnt_next;
  logic                 tick;
  logic [N*N*W-1:0]     a_snap_reg, a_snap_next;
  logic [N*N*W-1:0]     b_snap_reg, b_snap_next;
  logic [WAVE_W-1:0]    wave_reg, wave_next;
  logic [WDW-1:0]       wd_reg, wd_next;
  logic [N*N-1:0]       mac_start_reg, mac_start_next;
  logic [N*W-1:0]       a_row_reg, a_row_next;
  logic [N*W-1:0]       b_col_reg, b_col_next;
  logic                 err_reg, err_next;
  logic [N*N-1:0]       active_mask;
  logic                 all_done;
  logic [N*W-1:0]       a_ops, b_ops;

  assign tick          = (tick_cnt_reg == TCW'(TICK_DIV-1));
  assign tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;

  // PE(i,j) works on wave k while its diagonal offset k-i-j lies in 0..N-1.
  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign active_mask[gi*N+gj] = (int'(wave_reg) >= gi+gj) &&
                                      (int'(wave_reg) <= gi+gj+N-1);
      end
    end
  endgenerate

  assign all_done = ((mac_done & active_mask) == active_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      tick_cnt_reg  <= '0;
      a_snap_reg    <= '0;
      b_snap_reg    <= '0;
      wave_reg      <= '0;
      wd_reg        <= '0;
      mac_start_reg <= '0;
      a_row_reg     <= '0;
      b_col_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      if (tick) begin
        state_reg     <= state_next;
        a_snap_reg    <= a_snap_next;
        b_snap_reg    <= b_snap_next;
        wave_reg      <= wave_next;
        wd_reg        <= wd_next;
        mac_start_reg <= mac_start_next;
        a_row_reg     <= a_row_next;
        b_col_reg     <= b_col_next;
        err_reg       <= err_next;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    a_snap_next    = a_snap_reg;
    b_snap_next    = b_snap_reg;
    wave_next      = wave_reg;
    wd_next        = wd_reg;
    err_next       = err_reg;
    mac_start_next = '0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_snap_next = a_flat;
          b_snap_next = b_flat;
          wave_next   = '0;
          err_next    = 1'b0;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        mac_start_next = active_mask;
        state_next     = S_FIRE;
      end
      S_FIRE: begin
        wd_next    = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked first so it wins over a same-tick watchdog expiry.
        if (all_done) begin
          if (int'(wave_reg) == LAST_WAVE) begin
            state_next = S_DONE;
          end else begin
            wave_next  = wave_reg + 1'b1;
            state_next = S_LOAD;
          end
        end else if ((wd_reg + 1'b1) == WDW'(TIMEOUT)) begin
          err_next   = 1'b1;
          wave_next  = '0;
          wd_next    = '0;
          state_next = S_IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands for the wave being entered, read from the snapshot that will be in
  // force, so a fresh start feeds wave 0 from the values latched on that same tick.
  always_comb begin
    a_ops = '0;
    b_ops = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (int'(wave_next) == i+j) begin
          a_ops[i*W +: W] = a_snap_next[(i*N+j)*W +: W];
          b_ops[j*W +: W] = b_snap_next[(i*N+j)*W +: W];
        end
      end
    end
  end

  always_comb begin
    a_row_next = '0;
    b_col_next = '0;
    case (state_next)
      S_LOAD: begin
        a_row_next = a_ops;
        b_col_next = b_ops;
      end
      S_FIRE, S_WAIT: begin
        a_row_next = a_row_reg;
        b_col_next = b_col_reg;
      end
      default: begin
        a_row_next = '0;
        b_col_next = '0;
      end
    endcase
  end

  assign mac_start = mac_start_reg;
  assign a_row_in  = a_row_reg;
  assign b_col_in  = b_col_reg;
  assign wave      = wave_reg;
  assign err       = err_reg;
  assign busy      = (state_reg == S_LOAD) || (state_reg == S_FIRE) || (state_reg == S_WAIT);
  assign done      = (state_reg == S_DONE);

endmodule
